// File: rtl/rom_bit_serializer.sv
// rom_bit_serializer
// ------------------
// Pattern/sequence generator. A free-running 3-bit counter selects a bit
// position, and a 3-bit select picks one of eight fixed 8-bit pattern words.
// The chosen bit of the chosen word is presented on outp, so over eight
// consecutive clocks the word is shifted out LSB first. The counter keeps
// running whatever en and s do.
//
// Ports:
//   clk   in   1  rising-edge clock
//   clr   in   1  synchronous active-high clear of the counter
//   en    in   1  decoder enable; low forces outp to 0
//   s     in   3  pattern word select (s[2] is the MSB)
//   outp  out  1  serial output bit, combinational from q, s and en
//   q     out  3  current counter value, which is also the bit index
module rom_bit_serializer (
    input  logic       clk,
    input  logic       clr,
    input  logic       en,
    input  logic [2:0] s,
    output logic       outp,
    output logic [2:0] q
);

    logic [7:0] word;
    logic [7:0] dec;
    logic [7:0] e;

    // Bit-index counter. It counts up every clock and wraps from 7 back to 0
    // through the natural 3-bit overflow. A high clr pins it at zero, and
    // counting resumes from 1 on the first edge after clr drops.
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= 3'd0;
        end else begin
            q <= q + 3'd1;
        end
    end

    // Fixed pattern table. It is read combinationally, so a change on s is
    // visible on outp within the same cycle, without waiting for a clock.
    always_comb begin
        word = 8'h00;
        case (s)
            3'd0: word = 8'hA5;
            3'd1: word = 8'h3C;
            3'd2: word = 8'hF0;
            3'd3: word = 8'h0F;
            3'd4: word = 8'h55;
            3'd5: word = 8'hAA;
            3'd6: word = 8'hFF;
            3'd7: word = 8'h81;
            default: word = 8'h00;
        endcase
    end

    // One-hot decoder of the counter. Only the line matching the current bit
    // index is raised, and only while en is high. With en low every line is
    // zero, which is what silences the output.
    always_comb begin
        dec = 8'h00;
        for (int i = 0; i < 8; i++) begin
            dec[i] = en && (q == 3'(i));
        end
    end

    // Output path. Each decoder line gates its own word bit, and the gated
    // bits are OR-ed together. Because at most one line is high, this amounts
    // to en & word[q]. Built as gate-and-OR rather than a mux, it mirrors the
    // decoder-plus-ROM structure of the original lab design.
    always_comb begin
        e    = dec & word;
        outp = |e;
    end

endmodule

// File: tb/tb_rom_bit_serializer.sv
// tb_rom_bit_serializer
// ---------------------
// Directed bench for rom_bit_serializer. Each stimulus step drives the
// inputs just after a rising edge and queues the hand-derived q/outp values
// expected for that cycle. An independent monitor pops those entries and
// compares them against the DUT on the falling edge, or right after a
// mid-cycle select change, when the stimulus signals one.
module tb_rom_bit_serializer;

    logic       clk;
    logic       clr;
    logic       en;
    logic [2:0] s;
    logic       outp;
    logic [2:0] q;

    typedef struct {
        logic [2:0] q;
        logic       o;
        string      tag;
    } exp_t;

    exp_t       sb[$];
    int         vectors;
    int         miscompares;
    event       midCheck;
    logic [7:0] romT [8];
    int         qExp;

    rom_bit_serializer dut (
        .clk  (clk),
        .clr  (clr),
        .en   (en),
        .s    (s),
        .outp (outp),
        .q    (q)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog, so that a stuck run still prints a FAIL line and ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: timeout reached, required run to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive the inputs for one cycle and queue what the DUT must show
    // during that cycle.
    task automatic applyStimulus(input logic clrV, input logic enV,
                                 input logic [2:0] sV, input logic [2:0] expQ,
                                 input logic expO, input string tag);
        exp_t ent;
        @(posedge clk);
        #1;
        clr = clrV;
        en  = enV;
        s   = sV;
        ent.q   = expQ;
        ent.o   = expO;
        ent.tag = tag;
        sb.push_back(ent);
    endtask

    // Change s partway through a cycle, with no clock edge involved, and ask
    // the monitor to check the combinational response straight away.
    task automatic applyMidChange(input logic [2:0] sV, input logic [2:0] expQ,
                                  input logic expO, input string tag);
        exp_t ent;
        @(negedge clk);
        #2;
        s = sV;
        ent.q   = expQ;
        ent.o   = expO;
        ent.tag = tag;
        sb.push_back(ent);
        #1;
        -> midCheck;
    endtask

    // Compare one queued expectation against the DUT outputs.
    task automatic checkOutput(input exp_t ent);
        vectors++;
        if (q !== ent.q) begin
            miscompares++;
            $display("[TB] FAIL %s q: got %0d, required %0d", ent.tag, q, ent.q);
        end
        vectors++;
        if (outp !== ent.o) begin
            miscompares++;
            $display("[TB] FAIL %s outp: got %b, required %b", ent.tag, outp, ent.o);
        end
    endtask

    // Monitor: on each falling edge, or on a mid-cycle check request, pop
    // at most one expectation and compare it.
    initial begin
        forever begin
            @(negedge clk or midCheck);
            if (sb.size() > 0) begin
                checkOutput(sb.pop_front());
            end
        end
    end

    // Stimulus sequence.
    initial begin
        romT[0] = 8'hA5; romT[1] = 8'h3C; romT[2] = 8'hF0; romT[3] = 8'h0F;
        romT[4] = 8'h55; romT[5] = 8'hAA; romT[6] = 8'hFF; romT[7] = 8'h81;
        vectors     = 0;
        miscompares = 0;
        clr = 1'b1;
        en  = 1'b0;
        s   = 3'd0;
        @(posedge clk);
        @(posedge clk);

        // Reset release: A5 LSB first gives 1,0,1,0,0,1,0,1.
        applyStimulus(0, 1, 0, 0, 1, "rst_q0");
        applyStimulus(0, 1, 0, 1, 0, "a5_b1");
        applyStimulus(0, 1, 0, 2, 1, "a5_b2");
        applyStimulus(0, 1, 0, 3, 0, "a5_b3");
        applyStimulus(0, 1, 0, 4, 0, "a5_b4");
        applyStimulus(0, 1, 0, 5, 1, "a5_b5");
        applyStimulus(0, 1, 0, 6, 0, "a5_b6");
        applyStimulus(0, 1, 0, 7, 1, "a5_b7");

        // Word 1 (3C) from q=0, after the wrap: 0,0,1,1,1,1,0,0.
        applyStimulus(0, 1, 1, 0, 0, "3c_b0");
        applyStimulus(0, 1, 1, 1, 0, "3c_b1");
        applyStimulus(0, 1, 1, 2, 1, "3c_b2");
        applyStimulus(0, 1, 1, 3, 1, "3c_b3");
        applyStimulus(0, 1, 1, 4, 1, "3c_b4");
        applyStimulus(0, 1, 1, 5, 1, "3c_b5");
        applyStimulus(0, 1, 1, 6, 0, "3c_b6");
        applyStimulus(0, 1, 1, 7, 0, "3c_b7");

        // Word 7 (81): 1,0,0,0,0,0,0,1.
        applyStimulus(0, 1, 7, 0, 1, "81_b0");
        applyStimulus(0, 1, 7, 1, 0, "81_b1");
        applyStimulus(0, 1, 7, 2, 0, "81_b2");
        applyStimulus(0, 1, 7, 3, 0, "81_b3");
        applyStimulus(0, 1, 7, 4, 0, "81_b4");
        applyStimulus(0, 1, 7, 5, 0, "81_b5");
        applyStimulus(0, 1, 7, 6, 0, "81_b6");
        applyStimulus(0, 1, 7, 7, 1, "81_b7");

        // Word 6 (FF): constant 1.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1, 6, 3'(i), 1, "ff_const");
        end

        // Enable low for 16 cycles with every select: outp stays 0 while q
        // keeps counting.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 0, 3'(i % 8), 3'(i % 8), 0, "en_low");
        end

        // Enable raised at q=3 with word 2 (F0): bit 3 is 0, bit 4 is 1.
        applyStimulus(0, 0, 2, 0, 0, "en_low_q0");
        applyStimulus(0, 0, 2, 1, 0, "en_low_q1");
        applyStimulus(0, 0, 2, 2, 0, "en_low_q2");
        applyStimulus(0, 1, 2, 3, 0, "en_up_q3");
        applyStimulus(0, 1, 2, 4, 1, "en_up_q4");

        // Mid-run clear at q=5, held over three edges, with word 3 (0F).
        applyStimulus(1, 1, 2, 5, 1, "clr_at_q5");
        applyStimulus(1, 1, 3, 0, 1, "clr_hold1");
        applyStimulus(1, 1, 3, 0, 1, "clr_hold2");
        applyStimulus(0, 1, 3, 0, 1, "clr_hold3");
        applyStimulus(0, 1, 3, 1, 1, "clr_rel_q1");
        applyStimulus(0, 1, 3, 2, 1, "clr_rel_q2");

        // Pass through the 7->0 wrap on word 4 (55), then switch to word 5
        // (AA) mid-cycle at q=2: outp falls from 1 to 0 with no clock edge.
        applyStimulus(0, 1, 4, 3, 0, "55_b3");
        applyStimulus(0, 1, 4, 4, 1, "55_b4");
        applyStimulus(0, 1, 4, 5, 0, "55_b5");
        applyStimulus(0, 1, 4, 6, 1, "55_b6");
        applyStimulus(0, 1, 4, 7, 0, "55_b7");
        applyStimulus(0, 1, 4, 0, 1, "wrap_q0");
        applyStimulus(0, 1, 4, 1, 0, "55_b1");
        applyStimulus(0, 1, 4, 2, 1, "55_b2");
        applyMidChange(5, 2, 0, "mid_sel_aa_b2");
        applyStimulus(0, 1, 5, 3, 1, "aa_b3");

        // Sweep: eight consecutive cycles per select value cover every
        // (s, q) pair. The counter is at 4 on the first cycle here.
        qExp = 4;
        for (int k = 0; k < 64; k++) begin
            applyStimulus(0, 1, 3'(k / 8), 3'(qExp),
                          romT[k / 8][qExp], $sformatf("sweep_s%0d_q%0d", k / 8, qExp));
            qExp = (qExp + 1) % 8;
        end

        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d entries left unchecked, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
